// File: rtl/dot_pkg.sv
// Shared constants and FSM state encoding for the vector dot-product MAC.
// Optional feature macro: DOT_SIGNED_EN (two's-complement operands and result).
package dot_pkg;

    // Default geometry of one dot-product engine
    localparam int unsigned DOT_DATA_W  = 11;
    localparam int unsigned DOT_VEC_LEN = 4;

    // Engine control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } dot_state_e;

    // Element counter width: must hold the value VEC_LEN itself
    function automatic int unsigned dot_cnt_w(input int unsigned vec_len);
        return $clog2(vec_len + 1);
    endfunction

    // Accumulator width: full product plus enough guard bits for VEC_LEN additions
    function automatic int unsigned dot_acc_w(input int unsigned data_w,
                                              input int unsigned vec_len);
        return 2 * data_w + $clog2(vec_len + 1);
    endfunction

endpackage

// File: rtl/dot_mul.sv
// Combinational DATA_W x DATA_W multiplier, result extended to the accumulator width.
// DOT_SIGNED_EN defined: operands are two's-complement, product is sign-extended.
// DOT_SIGNED_EN undefined: operands are unsigned, product is zero-extended.
module dot_mul
    import dot_pkg::*;
#(
    parameter int unsigned DATA_W = DOT_DATA_W,
    parameter int unsigned ACC_W  = dot_acc_w(DOT_DATA_W, DOT_VEC_LEN)
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  prod_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    // Guard bits above the full-width product (at least one since VEC_LEN >= 1)
    localparam int unsigned EXT_W  = ACC_W - PROD_W;

    logic [PROD_W-1:0] prod;

`ifdef DOT_SIGNED_EN
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    // Sign-extend operands to full product width so the multiply is exact
    always_comb begin
        a_ext  = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i});
        b_ext  = $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
        prod   = a_ext * b_ext;
        prod_o = {{EXT_W{prod[PROD_W-1]}}, prod};
    end
`else
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;

    // Zero-extend operands to full product width so the multiply is exact
    always_comb begin
        a_ext  = {{DATA_W{1'b0}}, a_i};
        b_ext  = {{DATA_W{1'b0}}, b_i};
        prod   = a_ext * b_ext;
        prod_o = {{EXT_W{1'b0}}, prod};
    end
`endif

endmodule

// File: rtl/vector_dot_mac.sv
// Streaming multiply-accumulate engine: S = sum(k[i] * l[i]) over VEC_LEN element pairs.
// Pairs arrive on a valid/ready handshake; the finished sum is held until out_ready.
// Optional feature macro: DOT_SIGNED_EN (handled inside dot_mul; the adder is
// sign-agnostic because products arrive already extended to ACC_W).
module vector_dot_mac
    import dot_pkg::*;
#(
    parameter int unsigned DATA_W  = DOT_DATA_W,
    parameter int unsigned VEC_LEN = DOT_VEC_LEN,
    parameter int unsigned CNT_W   = dot_cnt_w(VEC_LEN),
    parameter int unsigned ACC_W   = dot_acc_w(DATA_W, VEC_LEN)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] k,
    input  logic [DATA_W-1:0] l,
    output logic              busy,
    output logic [CNT_W-1:0]  elem_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  S
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    dot_state_e       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] prod;
    logic             beat;

    dot_mul #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .a_i    (k),
        .b_i    (l),
        .prod_o (prod)
    );

    // Next-state, accumulator/counter update and handshake outputs
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        beat      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // S and elem_idx keep the last result until a new product begins
                if (start) begin
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                beat     = in_valid;
                if (beat) begin
                    sum_d = sum_q + prod;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // start in the same cycle is deliberately not honoured here
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any partial sum
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
        end
    end

    assign S        = sum_q;
    assign elem_idx = idx_q;

endmodule

// File: tb/tb_vector_dot_mac.sv
// Self-checking bench for vector_dot_mac with an expected-result scoreboard.
// Build with DOT_SIGNED_EN defined to exercise the signed configuration.
module tb_vector_dot_mac;
    import dot_pkg::*;

    localparam int unsigned DATA_W  = DOT_DATA_W;
    localparam int unsigned VEC_LEN = DOT_VEC_LEN;
    localparam int unsigned CNT_W   = dot_cnt_w(VEC_LEN);
    localparam int unsigned ACC_W   = dot_acc_w(DATA_W, VEC_LEN);
    localparam int          TMO     = 40;

    typedef logic [DATA_W-1:0] elem_t;
    typedef logic [ACC_W-1:0]  acc_t;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    elem_t            k;
    elem_t            l;
    logic             busy;
    logic [CNT_W-1:0] elem_idx;
    logic             out_valid;
    logic             out_ready;
    acc_t             S;

    int   n_checks = 0;
    int   n_pass   = 0;
    acc_t sb[$];

    vector_dot_mac #(
        .DATA_W  (DATA_W),
        .VEC_LEN (VEC_LEN),
        .CNT_W   (CNT_W),
        .ACC_W   (ACC_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .k         (k),
        .l         (l),
        .busy      (busy),
        .elem_idx  (elem_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Reference dot product
    function automatic acc_t dot_model(input elem_t ka[VEC_LEN], input elem_t la[VEC_LEN]);
        longint acc = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
`ifdef DOT_SIGNED_EN
            acc += longint'($signed(ka[i])) * longint'($signed(la[i]));
`else
            acc += longint'(ka[i]) * longint'(la[i]);
`endif
        end
        return acc_t'(acc);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present pairs lo..hi, idling `gap` cycles after each accepted beat
    task automatic drive_beats(input elem_t ka[VEC_LEN], input elem_t la[VEC_LEN],
                               input int lo, input int hi, input int gap);
        for (int i = lo; i <= hi; i++) begin
            k        = ka[i];
            l        = la[i];
            in_valid = 1'b1;
            for (int w = 0; w < TMO && !in_ready; w++) tick();
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_out_valid(output bit seen);
        int n = 0;
        while (!out_valid && n < TMO) begin
            tick();
            n++;
        end
        seen = out_valid;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        k        = elem_t'(7);
        l        = elem_t'(9);
        repeat (3) tick();
        n_checks++;
        if (S !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0
            || elem_idx !== '0) begin
            $display("FAIL reset: S=%0d out_valid=%b in_ready=%b busy=%b idx=%0d, want all 0",
                     S, out_valid, in_ready, busy, elem_idx);
        end else n_pass++;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL reset_idle: busy=%b in_ready=%b, want 0 0", busy, in_ready);
        end else n_pass++;
    endtask

    task automatic test_basic();
        elem_t ka[VEC_LEN] = '{elem_t'(1), elem_t'(2), elem_t'(3), elem_t'(4)};
        elem_t la[VEC_LEN] = '{elem_t'(5), elem_t'(6), elem_t'(7), elem_t'(8)};
        acc_t  exp;
        sb.push_back(dot_model(ka, la));
        pulse_start();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL basic_accum: in_ready=%b busy=%b, want 1 1", in_ready, busy);
        end else n_pass++;
        // Back-to-back beats; out_valid must stay low until the last beat's edge
        for (int i = 0; i < VEC_LEN; i++) begin
            k        = ka[i];
            l        = la[i];
            in_valid = 1'b1;
            tick();
            if (i == VEC_LEN - 2) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL basic_early: out_valid=%b before last beat, want 0",
                             out_valid);
                end else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || elem_idx !== CNT_W'(VEC_LEN)) begin
            $display("FAIL basic_latency: out_valid=%b in_ready=%b idx=%0d, want 1 0 %0d",
                     out_valid, in_ready, elem_idx, VEC_LEN);
        end else n_pass++;
        exp = sb.pop_front();
        n_checks++;
        if (S !== exp || S !== acc_t'(70)) begin
            $display("FAIL basic_sum: S=%0d, want %0d", S, exp);
        end else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || S !== exp || elem_idx !== CNT_W'(VEC_LEN))
        begin
            $display("FAIL basic_exit: out_valid=%b busy=%b S=%0d idx=%0d, want 0 0 %0d %0d",
                     out_valid, busy, S, elem_idx, exp, VEC_LEN);
        end else n_pass++;
    endtask

    task automatic test_stalls();
        elem_t ka[VEC_LEN] = '{elem_t'(1), elem_t'(2), elem_t'(3), elem_t'(4)};
        elem_t la[VEC_LEN] = '{elem_t'(5), elem_t'(6), elem_t'(7), elem_t'(8)};
        acc_t  exp;
        bit    seen;
        sb.push_back(dot_model(ka, la));
        pulse_start();
        drive_beats(ka, la, 0, VEC_LEN - 1, 2);
        wait_out_valid(seen);
        n_checks++;
        if (!seen) $display("FAIL stall_timeout: out_valid=%b, want 1", out_valid);
        else n_pass++;
        exp = sb.pop_front();
        // Consumer holds off; offered pairs must not be taken
        k         = elem_t'(9);
        l         = elem_t'(9);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (S !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL stall_hold[%0d]: S=%0d out_valid=%b in_ready=%b, want %0d 1 0",
                         c, S, out_valid, in_ready, exp);
            end else n_pass++;
        end
        in_valid = 1'b0;
        // start together with out_ready: only the exit happens
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || S !== exp) begin
            $display("FAIL stall_exit_start: busy=%b out_valid=%b S=%0d, want 0 0 %0d",
                     busy, out_valid, S, exp);
        end else n_pass++;
    endtask

    task automatic test_max();
        elem_t ka[VEC_LEN];
        elem_t la[VEC_LEN];
        acc_t  exp;
        bit    seen;
        for (int i = 0; i < VEC_LEN; i++) begin
            ka[i] = elem_t'(2047);
            la[i] = elem_t'(2047);
        end
        sb.push_back(dot_model(ka, la));
        pulse_start();
        drive_beats(ka, la, 0, VEC_LEN - 1, 0);
        wait_out_valid(seen);
        exp = sb.pop_front();
        n_checks++;
`ifdef DOT_SIGNED_EN
        if (!seen || S !== exp || S !== acc_t'(4)) begin
`else
        if (!seen || S !== exp || S !== acc_t'(16760836)) begin
`endif
            $display("FAIL max_sum: out_valid=%b S=%0d, want 1 %0d", out_valid, S, exp);
        end else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        elem_t ka[VEC_LEN] = '{elem_t'(3), elem_t'(3), elem_t'(3), elem_t'(3)};
        elem_t la[VEC_LEN] = '{elem_t'(3), elem_t'(3), elem_t'(3), elem_t'(3)};
        elem_t oa[VEC_LEN] = '{elem_t'(1), elem_t'(1), elem_t'(1), elem_t'(1)};
        acc_t  exp;
        bit    seen;
        pulse_start();
        drive_beats(ka, la, 0, 1, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (S !== '0 || elem_idx !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL abort_reset: S=%0d idx=%0d busy=%b out_valid=%b, want 0 0 0 0",
                     S, elem_idx, busy, out_valid);
        end else n_pass++;
        sb.push_back(dot_model(oa, oa));
        pulse_start();
        drive_beats(oa, oa, 0, VEC_LEN - 1, 0);
        wait_out_valid(seen);
        exp = sb.pop_front();
        n_checks++;
        if (!seen || S !== exp || S !== acc_t'(4)) begin
            $display("FAIL abort_next: out_valid=%b S=%0d, want 1 %0d", out_valid, S, exp);
        end else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_signed_start_ignored();
`ifdef DOT_SIGNED_EN
        elem_t ka[VEC_LEN] = '{elem_t'(-1), elem_t'(2), elem_t'(-3), elem_t'(4)};
`else
        elem_t ka[VEC_LEN] = '{elem_t'(1), elem_t'(2), elem_t'(3), elem_t'(4)};
`endif
        elem_t la[VEC_LEN] = '{elem_t'(5), elem_t'(5), elem_t'(5), elem_t'(5)};
        elem_t ha[VEC_LEN];
        acc_t  exp;
        acc_t  partial;
        bit    seen;
        ha = '{ka[0], ka[1], elem_t'(0), elem_t'(0)};
        partial = dot_model(ha, la);
        sb.push_back(dot_model(ka, la));
        pulse_start();
        drive_beats(ka, la, 0, 1, 0);
        pulse_start();
        n_checks++;
        if (elem_idx !== CNT_W'(2) || S !== partial || busy !== 1'b1) begin
            $display("FAIL start_in_accum: idx=%0d S=%0d busy=%b, want 2 %0d 1",
                     elem_idx, S, busy, partial);
        end else n_pass++;
        drive_beats(ka, la, 2, VEC_LEN - 1, 0);
        wait_out_valid(seen);
        exp = sb.pop_front();
        n_checks++;
`ifdef DOT_SIGNED_EN
        if (!seen || S !== exp || S !== acc_t'(10)) begin
`else
        if (!seen || S !== exp || S !== acc_t'(50)) begin
`endif
            $display("FAIL signed_sum: out_valid=%b S=%0d, want 1 %0d", out_valid, S, exp);
        end else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        k         = '0;
        l         = '0;
        #1;
        test_reset();
        test_basic();
        test_stalls();
        test_max();
        test_abort();
        test_signed_start_ignored();
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d results left, want 0", sb.size());
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
